fetch_ctrl: RTL

- Sequences instruction fetch against a synchronous single-port instruction ROM with 1-cycle read latency.
- Owns the PC and generates the ROM chip-enable and address.
- Buffers returned words in a 2-entry queue and presents them to decode with a valid/ready handshake.
- Handles pipeline stall and branch redirect; sits between the PC/ROM pair and the IF/ID register.

---
 rtl/fetch_ctrl_pkg.sv | 16 +
 rtl/fetch_queue.sv | 71 +++++++
 rtl/fetch_ctrl.sv | 86 ++++++++
 3 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch slice: FSM encoding,
// default widths and the reset value presented on the instruction output.
package fetch_ctrl_pkg;

   localparam int unsigned DEF_PC_W   = 32;
   localparam int unsigned DEF_INST_W = 32;

   localparam logic [DEF_INST_W-1:0] NOP = '0;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      STALLED = 2'd2
   } state_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry {pc, inst} FIFO feeding decode. Entry 0 is the head and is held
// in registers, so the head outputs come straight from flops.
module fetch_queue
   import fetch_ctrl_pkg::*;
#(
   parameter int unsigned PC_W   = DEF_PC_W,
   parameter int unsigned INST_W = DEF_INST_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [PC_W-1:0]   push_pc,
   input  logic [INST_W-1:0] push_inst,
   input  logic              pop,
   input  logic              clear,
   output logic [1:0]        count,
   output logic              head_valid,
   output logic [PC_W-1:0]   head_pc,
   output logic [INST_W-1:0] head_inst
);

   logic [PC_W-1:0]   pc1;
   logic [INST_W-1:0] inst1;
   logic              do_pop;

   assign do_pop     = pop && (count != 2'd0);
   assign head_valid = (count != 2'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count     <= '0;
         head_pc   <= '0;
         head_inst <= INST_W'(NOP);
         pc1       <= '0;
         inst1     <= '0;
      end else if (clear) begin
         // A pop coinciding with clear is already consumed by decode.
         count <= '0;
      end else if (push && do_pop) begin
         if (count == 2'd1) begin
            head_pc   <= push_pc;
            head_inst <= push_inst;
         end else begin
            head_pc   <= pc1;
            head_inst <= inst1;
            pc1       <= push_pc;
            inst1     <= push_inst;
         end
      end else if (push) begin
         if (count == 2'd0) begin
            head_pc   <= push_pc;
            head_inst <= push_inst;
         end else begin
            pc1   <= push_pc;
            inst1 <= push_inst;
         end
         count <= count + 2'd1;
      end else if (do_pop) begin
         head_pc   <= pc1;
         head_inst <= inst1;
         count     <= count - 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (!(push && !do_pop && !clear && count == 2'd2));
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues reads to a 1-cycle-latency ROM and
// queues returned words for decode, handling stall and branch redirect.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int unsigned     PC_W     = DEF_PC_W,
   parameter int unsigned     INST_W   = DEF_INST_W,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              branch_i,
   input  logic [PC_W-1:0]   branch_target_i,
   output logic              rom_ce_o,
   output logic [PC_W-1:0]   rom_addr_o,
   input  logic [INST_W-1:0] rom_data_i,
   output logic              inst_valid_o,
   output logic [INST_W-1:0] inst_o,
   output logic [PC_W-1:0]   inst_pc_o,
   input  logic              inst_ready_i
);

   state_t            state;
   logic [PC_W-1:0]   pc;
   logic [PC_W-1:0]   req_pc;
   logic [PC_W-1:0]   target;
   logic              inflight;
   logic              drop;
   logic [1:0]        count;
   logic              pop;
   logic              push;
   logic              credit;

   assign target     = branch_target_i & ~PC_W'(3);
   assign pop        = inst_valid_o & inst_ready_i;
   assign push       = inflight & ~drop;
   assign rom_addr_o = pc;

   // Count words already owned (queued or returning) net of this cycle's pop.
   assign credit   = (({1'b0, count} + {2'b00, inflight}) - {2'b00, pop}) < 3'd2;
   assign rom_ce_o = (state == RUN) & ~stall_i & ~branch_i & credit;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         pc       <= RESET_PC;
         req_pc   <= RESET_PC;
         inflight <= 1'b0;
         drop     <= 1'b0;
      end else begin
         case (state)
            IDLE:    state <= RUN;
            RUN:     if (stall_i) state <= STALLED;
            STALLED: if (!stall_i) state <= RUN;
            default: state <= IDLE;
         endcase
         inflight <= rom_ce_o;
         drop     <= branch_i & inflight;
         if (branch_i) begin
            pc <= target;
         end else if (rom_ce_o) begin
            pc     <= pc + PC_W'(4);
            req_pc <= pc;
         end
      end
   end

   fetch_queue #(
      .PC_W   (PC_W),
      .INST_W (INST_W)
   ) u_queue (
      .clk        (clk),
      .rst_n      (rst),
      .push       (push),
      .push_pc    (req_pc),
      .push_inst  (rom_data_i),
      .pop        (pop),
      .clear      (branch_i),
      .count      (count),
      .head_valid (inst_valid_o),
      .head_pc    (inst_pc_o),
      .head_inst  (inst_o)
   );

endmodule
